// File: rtl/maxpool_1d_stream_if.sv
// Stream bundle for the 1-D max-pool stage: sample input channel and pooled
// result output channel, each with a valid/ready handshake.
interface maxpool_1d_stream_if #(
  parameter int W = 16
);
  logic signed [W-1:0] x_data;
  logic                x_valid;
  logic                x_ready;
  logic signed [W-1:0] y_data;
  logic                y_valid;
  logic                y_ready;
  logic                y_last;

  // Environment side: feeds samples and consumes pooled results.
  modport master (
    output x_data, x_valid, y_ready,
    input  x_ready, y_data, y_valid, y_last
  );

  // Pooling stage side.
  modport slave (
    input  x_data, x_valid, y_ready,
    output x_ready, y_data, y_valid, y_last
  );
endinterface

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D max-pool: groups each N-sample frame into windows of P, emits
// the signed max of each window through a 2-entry output FIFO with a frame tag.
module maxpool_1d_stream #(
  parameter int W = 16,
  parameter int P = 2,
  parameter int N = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  maxpool_1d_stream_if.slave   io
);

  localparam int WCW = (P > 1) ? $clog2(P) : 1;
  localparam int FCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(P - 1);
  localparam logic [FCW-1:0] FRM_LAST = FCW'(N - 1);

  typedef enum logic {START, ACC} state_t;

  state_t              state, state_nxt;
  logic [WCW-1:0]      win_cnt, win_cnt_nxt;
  logic [FCW-1:0]      frame_cnt, frame_cnt_nxt;
  logic signed [W-1:0] run_max, run_max_nxt;
  logic signed [W-1:0] result;

  logic [W:0]          mem [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;

  logic accept, close, is_last, push, pop;

  // Outputs come straight from registered FIFO state only.
  assign io.x_ready = (count < 2'd2);
  assign io.y_valid = (count != 2'd0);
  assign {io.y_last, io.y_data} = mem[rd_ptr];

  always_comb begin
    accept        = io.x_valid && io.x_ready;
    pop           = io.y_valid && io.y_ready;
    is_last       = (frame_cnt == FRM_LAST);
    close         = (win_cnt == WIN_LAST) || is_last;
    push          = accept && close;
    // A window that opens and closes on the same sample passes it through.
    result        = (state == ACC && run_max > io.x_data) ? run_max : io.x_data;

    state_nxt     = state;
    win_cnt_nxt   = win_cnt;
    frame_cnt_nxt = frame_cnt;
    run_max_nxt   = run_max;

    if (accept) begin
      run_max_nxt = result;
      if (close) begin
        state_nxt     = START;
        win_cnt_nxt   = '0;
        frame_cnt_nxt = is_last ? '0 : frame_cnt + 1'b1;
      end else begin
        state_nxt     = ACC;
        win_cnt_nxt   = win_cnt + 1'b1;
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= START;
      win_cnt   <= '0;
      frame_cnt <= '0;
      run_max   <= '0;
    end else begin
      state     <= state_nxt;
      win_cnt   <= win_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      run_max   <= run_max_nxt;
    end
  end

  // Simultaneous push and pop at count==1 leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {is_last, result};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Directed bench for maxpool_1d_stream: three instances (P=2/N=9, P=3/N=9,
// P=1/N=4) driven by per-scenario tasks with hand-computed expectations.
module tb_maxpool_1d_stream;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_1d_stream_if #(.W(16)) ia ();
  maxpool_1d_stream_if #(.W(16)) ib ();
  maxpool_1d_stream_if #(.W(16)) ic ();

  maxpool_1d_stream #(.W(16), .P(2), .N(9)) dut_a (.clk(clk), .reset(reset), .io(ia));
  maxpool_1d_stream #(.W(16), .P(3), .N(9)) dut_b (.clk(clk), .reset(reset), .io(ib));
  maxpool_1d_stream #(.W(16), .P(1), .N(4)) dut_c (.clk(clk), .reset(reset), .io(ic));

  // y_ready modes: 0 low, 1 high, 2 toggle each cycle, 3 random
  int a_rmode = 0, b_rmode = 0, c_rmode = 0;

  always begin
    case (a_rmode)
      0: ia.y_ready = 1'b0;
      1: ia.y_ready = 1'b1;
      2: ia.y_ready = (ia.y_ready === 1'b1) ? 1'b0 : 1'b1;
      default: ia.y_ready = 1'($urandom_range(0, 1));
    endcase
    case (b_rmode)
      0: ib.y_ready = 1'b0;
      1: ib.y_ready = 1'b1;
      2: ib.y_ready = (ib.y_ready === 1'b1) ? 1'b0 : 1'b1;
      default: ib.y_ready = 1'($urandom_range(0, 1));
    endcase
    case (c_rmode)
      0: ic.y_ready = 1'b0;
      1: ic.y_ready = 1'b1;
      2: ic.y_ready = (ic.y_ready === 1'b1) ? 1'b0 : 1'b1;
      default: ic.y_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  end

  logic [16:0] a_out[$], b_out[$], c_out[$];
  int          a_pop_cyc[$], a_acc_cyc[$], c_acc_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      if (ia.y_valid && ia.y_ready) begin
        a_out.push_back({ia.y_last, ia.y_data});
        a_pop_cyc.push_back(cyc);
      end
      if (ia.x_valid && ia.x_ready) a_acc_cyc.push_back(cyc);
      if (ib.y_valid && ib.y_ready) b_out.push_back({ib.y_last, ib.y_data});
      if (ic.y_valid && ic.y_ready) c_out.push_back({ic.y_last, ic.y_data});
      if (ic.x_valid && ic.x_ready) c_acc_cyc.push_back(cyc);
    end
  end

  task automatic send_a(input int v);
    bit ok = 0;
    ia.x_data  = 16'(v);
    ia.x_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ia.x_ready) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      n_assert++; n_fail++;
      $display("FAIL send_a timeout: sample %0d not accepted, required accept within 200 cycles", v);
    end
    ia.x_valid = 1'b0;
  endtask

  task automatic send_b(input int v);
    bit ok = 0;
    ib.x_data  = 16'(v);
    ib.x_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ib.x_ready) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      n_assert++; n_fail++;
      $display("FAIL send_b timeout: sample %0d not accepted, required accept within 200 cycles", v);
    end
    ib.x_valid = 1'b0;
  endtask

  task automatic send_c(input int v);
    bit ok = 0;
    ic.x_data  = 16'(v);
    ic.x_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ic.x_ready) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      n_assert++; n_fail++;
      $display("FAIL send_c timeout: sample %0d not accepted, required accept within 200 cycles", v);
    end
    ic.x_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_assert++;
    if (ia.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", ia.y_valid); end
    n_assert++;
    if (ia.y_last !== 1'b0) begin n_fail++; $display("FAIL reset_y_last: got %b expected 0", ia.y_last); end
    n_assert++;
    if (ia.y_data !== 16'sd0) begin n_fail++; $display("FAIL reset_y_data: got %0d expected 0", ia.y_data); end
    n_assert++;
    if (ib.y_valid !== 1'b0 || ic.y_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_y_valid_bc: got %b%b expected 00", ib.y_valid, ic.y_valid);
    end
    reset = 1'b1;
    @(posedge clk); #2;
    n_assert++;
    if (ia.x_ready !== 1'b1) begin n_fail++; $display("FAIL reset_x_ready: got %b expected 1", ia.x_ready); end
  endtask

  task automatic test_basic_stream;
    int s[9]      = '{5, 3, -2, 7, 7, 1, 0, 0, 9};
    int exp_d[5]  = '{5, 7, 7, 0, 9};
    bit exp_l[5]  = '{0, 0, 0, 0, 1};
    int close_i[5] = '{1, 3, 5, 7, 8};
    a_rmode = 1;
    repeat (2) @(posedge clk); #2;
    a_out.delete(); a_pop_cyc.delete(); a_acc_cyc.delete();
    foreach (s[i]) send_a(s[i]);
    repeat (4) @(posedge clk); #2;
    n_assert++;
    if (a_out.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", a_out.size()); end
    n_assert++;
    if (a_acc_cyc.size() !== 9) begin n_fail++; $display("FAIL basic_accepts: got %0d expected 9", a_acc_cyc.size()); end
    for (int k = 0; k < 5 && k < a_out.size(); k++) begin
      n_assert++;
      if (a_out[k][15:0] !== 16'(exp_d[k]) || a_out[k][16] !== exp_l[k]) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got %0d last %b expected %0d last %b",
                 k, $signed(a_out[k][15:0]), a_out[k][16], exp_d[k], exp_l[k]);
      end
      if (a_acc_cyc.size() == 9) begin
        n_assert++;
        if (a_pop_cyc[k] !== a_acc_cyc[close_i[k]] + 1) begin
          n_fail++;
          $display("FAIL basic_latency[%0d]: got cycle %0d expected %0d", k, a_pop_cyc[k], a_acc_cyc[close_i[k]] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int s[9]     = '{5, 3, -2, 7, 7, 1, 0, 0, 9};
    int exp_d[5] = '{5, 7, 7, 0, 9};
    a_rmode = 0;
    repeat (2) @(posedge clk); #2;
    a_out.delete(); a_pop_cyc.delete(); a_acc_cyc.delete();
    fork
      foreach (s[i]) send_a(s[i]);
      begin
        repeat (12) @(posedge clk); #2;
        n_assert++;
        if (a_acc_cyc.size() !== 4) begin n_fail++; $display("FAIL bp_accepts_stalled: got %0d expected 4", a_acc_cyc.size()); end
        n_assert++;
        if (ia.x_ready !== 1'b0) begin n_fail++; $display("FAIL bp_x_ready: got %b expected 0", ia.x_ready); end
        n_assert++;
        if (ia.y_valid !== 1'b1 || ia.y_data !== 16'sd5) begin
          n_fail++; $display("FAIL bp_head: got valid %b data %0d expected valid 1 data 5", ia.y_valid, ia.y_data);
        end
        a_rmode = 1;
      end
    join
    repeat (6) @(posedge clk); #2;
    n_assert++;
    if (a_acc_cyc.size() !== 9) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 9", a_acc_cyc.size()); end
    n_assert++;
    if (a_out.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d expected 5", a_out.size()); end
    for (int k = 0; k < 5 && k < a_out.size(); k++) begin
      n_assert++;
      if (a_out[k][15:0] !== 16'(exp_d[k]) || a_out[k][16] !== (k == 4)) begin
        n_fail++;
        $display("FAIL bp_out[%0d]: got %0d last %b expected %0d last %b",
                 k, $signed(a_out[k][15:0]), a_out[k][16], exp_d[k], (k == 4));
      end
    end
  endtask

  task automatic test_back_to_back;
    int s[18]     = '{5, 3, -2, 7, 7, 1, 0, 0, 9, 1, 2, 3, 4, 5, 6, 7, 8, -1};
    int exp_d[10] = '{5, 7, 7, 0, 9, 2, 4, 6, 8, -1};
    a_rmode = 2;
    a_out.delete(); a_pop_cyc.delete(); a_acc_cyc.delete();
    foreach (s[i]) send_a(s[i]);
    repeat (10) @(posedge clk); #2;
    n_assert++;
    if (a_out.size() !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", a_out.size()); end
    for (int k = 0; k < 10 && k < a_out.size(); k++) begin
      n_assert++;
      if (a_out[k][15:0] !== 16'(exp_d[k]) || a_out[k][16] !== (k == 4 || k == 9)) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got %0d last %b expected %0d last %b",
                 k, $signed(a_out[k][15:0]), a_out[k][16], exp_d[k], (k == 4 || k == 9));
      end
    end
  endtask

  task automatic test_signed_extremes;
    int s[9]     = '{-4, -9, -1, 2, 2, 2, 32767, -32768, 0};
    int exp_d[3] = '{-1, 2, 32767};
    b_rmode = 1;
    repeat (2) @(posedge clk); #2;
    b_out.delete();
    foreach (s[i]) send_b(s[i]);
    repeat (4) @(posedge clk); #2;
    n_assert++;
    if (b_out.size() !== 3) begin n_fail++; $display("FAIL signed_count: got %0d expected 3", b_out.size()); end
    for (int k = 0; k < 3 && k < b_out.size(); k++) begin
      n_assert++;
      if (b_out[k][15:0] !== 16'(exp_d[k]) || b_out[k][16] !== (k == 2)) begin
        n_fail++;
        $display("FAIL signed_out[%0d]: got %0d last %b expected %0d last %b",
                 k, $signed(b_out[k][15:0]), b_out[k][16], exp_d[k], (k == 2));
      end
    end
  endtask

  task automatic test_reset_mid;
    int exp_d[5] = '{2, 4, 6, 8, 9};
    a_rmode = 0;
    repeat (2) @(posedge clk); #2;
    send_a(4); send_a(6); send_a(9);
    n_assert++;
    if (ia.y_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", ia.y_valid); end
    #2 reset = 1'b0;
    #1;
    n_assert++;
    if (ia.y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", ia.y_valid); end
    n_assert++;
    if (ia.x_ready !== 1'b1) begin n_fail++; $display("FAIL rst_x_ready: got %b expected 1", ia.x_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    a_rmode = 1;
    a_out.delete(); a_pop_cyc.delete(); a_acc_cyc.delete();
    repeat (2) @(posedge clk); #2;
    for (int v = 1; v <= 9; v++) send_a(v);
    repeat (4) @(posedge clk); #2;
    n_assert++;
    if (a_out.size() !== 5) begin n_fail++; $display("FAIL rst_count: got %0d expected 5", a_out.size()); end
    for (int k = 0; k < 5 && k < a_out.size(); k++) begin
      n_assert++;
      if (a_out[k][15:0] !== 16'(exp_d[k]) || a_out[k][16] !== (k == 4)) begin
        n_fail++;
        $display("FAIL rst_out[%0d]: got %0d last %b expected %0d last %b",
                 k, $signed(a_out[k][15:0]), a_out[k][16], exp_d[k], (k == 4));
      end
    end
  endtask

  task automatic test_passthrough;
    int s[4] = '{8, 6, 4, 2};
    for (int pass = 0; pass < 2; pass++) begin
      c_rmode = (pass == 0) ? 3 : 1;
      repeat (2) @(posedge clk); #2;
      c_out.delete(); c_acc_cyc.delete();
      foreach (s[i]) send_c(s[i]);
      c_rmode = 1;
      repeat (6) @(posedge clk); #2;
      n_assert++;
      if (c_out.size() !== 4) begin n_fail++; $display("FAIL pass%0d_count: got %0d expected 4", pass, c_out.size()); end
      for (int k = 0; k < 4 && k < c_out.size(); k++) begin
        n_assert++;
        if (c_out[k][15:0] !== 16'(s[k]) || c_out[k][16] !== (k == 3)) begin
          n_fail++;
          $display("FAIL pass%0d_out[%0d]: got %0d last %b expected %0d last %b",
                   pass, k, $signed(c_out[k][15:0]), c_out[k][16], s[k], (k == 3));
        end
      end
      if (pass == 1) begin
        for (int k = 1; k < 4 && k < c_acc_cyc.size(); k++) begin
          n_assert++;
          if (c_acc_cyc[k] !== c_acc_cyc[k-1] + 1) begin
            n_fail++;
            $display("FAIL pass_throughput[%0d]: got cycle %0d expected %0d", k, c_acc_cyc[k], c_acc_cyc[k-1] + 1);
          end
        end
      end
    end
  endtask

  initial begin
    ia.x_valid = 1'b0; ia.x_data = '0;
    ib.x_valid = 1'b0; ib.x_data = '0;
    ic.x_valid = 1'b0; ic.x_data = '0;
    test_reset;
    test_basic_stream;
    test_backpressure;
    test_back_to_back;
    test_signed_extremes;
    test_reset_mid;
    test_passthrough;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
